// File: rtl/serial_adder.sv
// Digit-serial unsigned adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB digit first.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a + ~b + cin.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned DIGIT_NZ = (DIGIT == 0) ? 1 : DIGIT;
    localparam int unsigned STEPS    = WIDTH / DIGIT_NZ;
    localparam int unsigned CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned DW       = DIGIT_NZ + 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT_NZ) != 0) begin : g_bad_cfg
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH (WIDTH=%0d DIGIT=%0d)",
                   WIDTH, DIGIT);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_d, done_d, cout_d;
    logic [WIDTH-1:0] sum_d;

    logic [DW-1:0]    dsum;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_in;

    // One digit of the ripple: low DIGIT bits of both operands plus the linking carry
    always_comb begin
        dsum      = DW'(a_q[DIGIT_NZ-1:0]) + DW'(b_q[DIGIT_NZ-1:0]) + DW'(carry_q);
        res_shift = WIDTH'({dsum[DIGIT_NZ-1:0], res_q} >> DIGIT_NZ);
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction folds into the captured B operand so the digit adder stays unchanged
    always_comb begin
        b_in = sub ? ~b : b;
    end
`else
    always_comb begin
        b_in = b;
    end
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum;
        cout_d  = cout;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT_NZ;
                b_d     = b_q >> DIGIT_NZ;
                res_d   = res_shift;
                carry_d = dsum[DIGIT_NZ];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = dsum[DIGIT_NZ];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            sum     <= sum_d;
            cout    <= cout_d;
        end
    end

endmodule
